// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared pipeline-register constants.
// Contents: default payload/control/destination widths and write-back control bit positions.
package pipe_stage_reg_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int CTRL_W_DEF   = 2;
    localparam int RD_W_DEF     = 5;
    localparam int REGWRITE_BIT = 0;
    localparam int MEMTOREG_BIT = 1;
endpackage

// File: rtl/pipe_stage_reg_slot.sv
// stage_slot: one valid+payload register with load and clear.
// Ports: clk_i, rst_i (sync, active-high), load_i captures the inputs and sets valid,
//        clear_i drops valid and ctrl (a/b/rd keep their values), *_o expose the held entry.
module stage_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [CTRL_W-1:0] ctrl_o
);
    logic              valid_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [RD_W-1:0]   rd_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            a_q     <= a_i;
            b_q     <= b_i;
            rd_q    <= rd_i;
            ctrl_q  <= ctrl_i;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign rd_o    = rd_q;
    assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional two-entry skid buffer.
// Ports: clk_i, rst_i (sync, active-high), start_i (run enable, low freezes state),
//        flush_i (drops all entries), in_valid_i/in_ready_o + a_i/b_i/rd_i/ctrl_i upstream,
//        out_valid_o/out_ready_i + a_o/b_o/rd_o/ctrl_o downstream, occ_o held-entry count.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        occ_o
);
    logic              in_fire, out_fire, do_flush;
    logic              main_v, main_load, main_clear, skid_v;
    logic [DATA_W-1:0] main_a, main_b, skid_a, skid_b, main_a_d, main_b_d;
    logic [RD_W-1:0]   main_rd, skid_rd, main_rd_d;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;

    always_comb begin
        do_flush    = start_i && flush_i;
        in_fire     = in_valid_i && in_ready_o && start_i && !flush_i;
        out_fire    = main_v && out_ready_i && start_i && !flush_i;
        // Main refills from skid when the head leaves with a second entry waiting,
        // otherwise from the input when it is empty or being vacated this edge.
        main_load   = (out_fire && skid_v) || (in_fire && (!main_v || out_fire));
        main_clear  = do_flush || (out_fire && !main_load);
        main_a_d    = skid_v ? skid_a : a_i;
        main_b_d    = skid_v ? skid_b : b_i;
        main_rd_d   = skid_v ? skid_rd : rd_i;
        main_ctrl_d = skid_v ? skid_ctrl : ctrl_i;
    end

    stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (main_load),
        .clear_i (main_clear),
        .a_i     (main_a_d),
        .b_i     (main_b_d),
        .rd_i    (main_rd_d),
        .ctrl_i  (main_ctrl_d),
        .valid_o (main_v),
        .a_o     (main_a),
        .b_o     (main_b),
        .rd_o    (main_rd),
        .ctrl_o  (main_ctrl)
    );

    if (SKID_EN) begin : g_skid
        logic skid_load, skid_clear, rdy_q, rdy_d;
        assign skid_load  = in_fire && main_v && !out_fire;
        assign skid_clear = do_flush || (out_fire && skid_v);
        // Ready is registered as "skid will be empty after this edge", cutting the
        // combinational path from out_ready_i.
        assign rdy_d      = skid_load ? 1'b0 : (skid_clear ? 1'b1 : !skid_v);

        always_ff @(posedge clk_i) begin
            rdy_q <= rst_i ? 1'b0 : rdy_d;
        end

        stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_skid (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (skid_load),
            .clear_i (skid_clear),
            .a_i     (a_i),
            .b_i     (b_i),
            .rd_i    (rd_i),
            .ctrl_i  (ctrl_i),
            .valid_o (skid_v),
            .a_o     (skid_a),
            .b_o     (skid_b),
            .rd_o    (skid_rd),
            .ctrl_o  (skid_ctrl)
        );
        assign in_ready_o = rdy_q && start_i;
    end else begin : g_noskid
        assign skid_v     = 1'b0;
        assign skid_a     = '0;
        assign skid_b     = '0;
        assign skid_rd    = '0;
        assign skid_ctrl  = '0;
        assign in_ready_o = start_i && !rst_i && (!main_v || out_ready_i);
    end

    assign out_valid_o = main_v;
    assign a_o         = main_a;
    assign b_o         = main_b;
    assign rd_o        = main_rd;
    assign ctrl_o      = main_v ? main_ctrl : '0;
    assign occ_o       = {1'b0, main_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg; instance 0 is SKID_EN=0, instance 1 is SKID_EN=1.
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, flush;
    logic [1:0]  iv, ordy, acc;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [1:0]  ctrl;
    logic        inr [2];
    logic        ov [2];
    logic [31:0] ao [2];
    logic [31:0] bo [2];
    logic [4:0]  rdo [2];
    logic [1:0]  co [2];
    logic [1:0]  occ [2];
    logic [70:0] q0 [$];
    logic [70:0] q1 [$];
    int          n_vec = 0, n_err = 0;
    int          ndel [2];

    pipe_stage_reg #(.SKID_EN(1'b0)) u_pass (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .in_valid_i(iv[0]), .in_ready_o(inr[0]),
        .a_i(a), .b_i(b), .rd_i(rd), .ctrl_i(ctrl),
        .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
        .a_o(ao[0]), .b_o(bo[0]), .rd_o(rdo[0]), .ctrl_o(co[0]), .occ_o(occ[0])
    );

    pipe_stage_reg #(.SKID_EN(1'b1)) u_skid (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .in_valid_i(iv[1]), .in_ready_o(inr[1]),
        .a_i(a), .b_i(b), .rd_i(rd), .ctrl_i(ctrl),
        .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
        .a_o(ao[1]), .b_o(bo[1]), .rd_o(rdo[1]), .ctrl_o(co[1]), .occ_o(occ[1])
    );

    task automatic chk(input string tag, input logic [70:0] got, input logic [70:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return k == 0 ? q0.size() : q1.size();
    endfunction

    // Inputs are set at the negedge; handshakes are evaluated 1ns later, ahead of the rising edge.
    task automatic cyc();
        logic [70:0] e;
        #1;
        acc = 2'b00;
        if (!rst && start && !flush) begin
            for (int k = 0; k < 2; k++) begin
                if (ov[k] && ordy[k]) begin
                    ndel[k]++;
                    if (qsize(k) == 0) chk($sformatf("unexpected_out%0d", k), 71'(ov[k]), 71'd0);
                    else begin
                        if (k == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk($sformatf("data%0d", k), {ao[k], bo[k], rdo[k], co[k]}, e);
                    end
                end
                if (iv[k] && inr[k]) begin
                    acc[k] = 1'b1;
                    if (k == 0) q0.push_back({a, b, rd, ctrl});
                    else q1.push_back({a, b, rd, ctrl});
                end
            end
        end
        if (rst || (start && flush)) begin
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] va);
        a = va; b = ~va; rd = va[4:0]; ctrl = va[1:0] | 2'b01;
    endtask

    initial begin
        logic [31:0] ea, ed;
        int cnt;
        rst = 1'b1; start = 1'b1; flush = 1'b0; iv = 2'b00; ordy = 2'b00;
        a = '0; b = '0; rd = '0; ctrl = '0;
        ndel[0] = 0; ndel[1] = 0;
        @(negedge clk);
        cyc(); cyc();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_occ%0d", k), 71'(occ[k]), 71'd0);
            chk($sformatf("rst_ov%0d", k), 71'(ov[k]), 71'd0);
            chk($sformatf("rst_out%0d", k), {ao[k], bo[k], rdo[k], co[k]}, 71'd0);
            chk($sformatf("rst_inr%0d", k), 71'(inr[k]), 71'd0);
        end
        rst = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) chk($sformatf("post_rst_inr%0d", k), 71'(inr[k]), 71'd1);

        // Single entry, one-edge latency, then empty.
        a = 32'h10; b = 32'hAA; rd = 5'd3; ctrl = 2'b01; iv = 2'b11; ordy = 2'b11;
        cyc();
        iv = 2'b00;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("lat_ov%0d", k), 71'(ov[k]), 71'd1);
            chk($sformatf("lat_out%0d", k), {ao[k], bo[k], rdo[k], co[k]}, {32'h10, 32'hAA, 5'd3, 2'b01});
        end
        cyc();
        for (int k = 0; k < 2; k++) chk($sformatf("lat_empty%0d", k), 71'(ov[k]), 71'd0);

        // Back-pressure fills skid; release drains A then B.
        ordy = 2'b00; iv = 2'b10;
        put(32'hA0); cyc();
        put(32'hB0); cyc();
        iv = 2'b00;
        chk("full_occ", 71'(occ[1]), 71'd2);
        chk("full_inr", 71'(inr[1]), 71'd0);
        ordy = 2'b10;
        chk("head_a", 71'(ao[1]), 71'h0A0);
        cyc();
        chk("head_b", 71'(ao[1]), 71'h0B0);
        cyc();
        chk("drained", 71'(ov[1]), 71'd0);

        // Flush at occ 2 with a simultaneous input that must be dropped.
        ordy = 2'b00; iv = 2'b10;
        put(32'hA1); cyc();
        put(32'hB1); cyc();
        chk("pre_flush_occ", 71'(occ[1]), 71'd2);
        put(32'hC0); flush = 1'b1;
        cyc();
        flush = 1'b0; iv = 2'b00;
        chk("flush_occ", 71'(occ[1]), 71'd0);
        chk("flush_ctrl", 71'(co[1]), 71'd0);
        chk("flush_ov", 71'(ov[1]), 71'd0);
        chk("flush_keep_a", 71'(ao[1]), 71'h0A1);
        ordy = 2'b11;
        cyc(); cyc();
        chk("flush_no_c", 71'(ov[1]), 71'd0);

        // start_i low freezes everything.
        ordy = 2'b00; iv = 2'b10;
        put(32'hD0); cyc();
        ea = ao[1]; ed = bo[1];
        start = 1'b0; iv = 2'b11; ordy = 2'b11;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_occ", 71'(occ[1]), 71'd1);
            chk("hold_out", {ov[1], ao[1], bo[1]}, {1'b1, 32'hD0, ~32'hD0});
            chk("hold_inr", {inr[0], inr[1], occ[0]}, 71'd0);
        end
        start = 1'b1; iv = 2'b00;
        cyc();
        chk("resume_occ", 71'(occ[1]), 71'd0);

        // Reset mid-stream at occ 2.
        ordy = 2'b00; iv = 2'b10;
        put(32'hE0); cyc();
        put(32'hF0); cyc();
        iv = 2'b00;
        chk("pre_rst_occ", 71'(occ[1]), 71'd2);
        rst = 1'b1;
        cyc();
        chk("mid_rst_out", {ov[1], occ[1], ao[1], bo[1], rdo[1], co[1]}, 71'd0);
        chk("mid_rst_inr", {inr[0], inr[1]}, 71'd0);
        rst = 1'b0;
        cyc();

        // Full throughput with out_ready_i held high.
        ordy = 2'b11; iv = 2'b11;
        for (int i = 0; i < 4; i++) begin
            put(32'h100 + 32'(i));
            cyc();
            chk("tput", 71'(acc), 71'd3);
        end
        iv = 2'b00;
        cyc(); cyc();

        // Randomised back-pressure stream, one instance at a time.
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            ndel[k] = 0;
            for (int c = 0; c < 400 && (cnt < 16 || qsize(k) != 0 || ov[k]); c++) begin
                iv[k] = cnt < 16;
                put(32'(cnt));
                ordy[k] = 1'($urandom_range(0, 1));
                cyc();
                if (acc[k]) cnt++;
                if (k == 0 && occ[0] > 2'd1) chk("pass_occ_max", 71'(occ[0]), 71'd1);
            end
            iv[k] = 1'b0;
            chk($sformatf("stream_in%0d", k), 71'(cnt), 71'd16);
            chk($sformatf("stream_out%0d", k), 71'(ndel[k]), 71'd16);
            chk($sformatf("stream_left%0d", k), 71'(qsize(k)), 71'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
